// File: rtl/trap_shaper_v3_pkg.sv
// Shared widths, types and config check for the trapezoidal shaper.
package package_settings_v3;

  localparam int unsigned DATA_W = 14;
  localparam int unsigned AW     = 6;
  localparam int unsigned M_W    = 10;
  localparam int unsigned ACC_W  = 40;
  localparam int unsigned OUT_W  = 16;
  localparam int unsigned D_W    = DATA_W + 2;

  typedef logic signed [DATA_W-1:0] sample_t;
  typedef logic signed [D_W-1:0]    diff_t;
  typedef logic signed [ACC_W-1:0]  acc_t;
  typedef logic signed [OUT_W-1:0]  out_t;
  typedef logic [AW-1:0]            addr_t;

  typedef struct packed {
    logic [AW-1:0]  k;
    logic [AW-1:0]  l;
    logic [M_W-1:0] m;
  } cfg_t;

  // Legal iff 1 <= k <= l and the deepest tap (k+l) fits inside the buffer.
  function automatic logic cfg_ok(cfg_t c);
    logic [AW:0] sum;
    sum = {1'b0, c.k} + {1'b0, c.l};
    return (c.k != '0) && (c.k <= c.l) && (sum <= {1'b0, {AW{1'b1}}});
  endfunction

endpackage

// File: rtl/trap_shaper_v3_if.sv
// Sample, config and output bundle of the trapezoidal shaper.
interface trap_shaper_v3_if;
  import package_settings_v3::*;

  logic           in_valid;
  sample_t        in_data;
  logic           cfg_load;
  logic [AW-1:0]  cfg_k;
  logic [AW-1:0]  cfg_l;
  logic [M_W-1:0] cfg_m;
  logic           cfg_err;
  logic           out_valid;
  out_t           out_data;
  logic           out_sat;

  modport master (
    output in_valid, in_data, cfg_load, cfg_k, cfg_l, cfg_m,
    input  cfg_err, out_valid, out_data, out_sat
  );

  modport slave (
    input  in_valid, in_data, cfg_load, cfg_k, cfg_l, cfg_m,
    output cfg_err, out_valid, out_data, out_sat
  );

endinterface

// File: rtl/trap_shaper_v3_delay.sv
// Circular sample history with one write port and three combinational taps.
module trap_delay_line
  import package_settings_v3::*;
(
  input  logic    clk,
  input  logic    reset,
  input  logic    clr,
  input  logic    wr_en,
  input  sample_t wr_data,
  input  addr_t   k,
  input  addr_t   l,
  output sample_t tap_k_c,
  output sample_t tap_l_c,
  output sample_t tap_kl_c
);

  localparam int unsigned DEPTH = 1 << AW;

  sample_t mem [DEPTH];
  addr_t   wr_ptr;

  // Clearing the whole array makes unwritten history read as zero during warm-up.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      mem    <= '{default: '0};
    end else if (clr) begin
      wr_ptr <= '0;
      mem    <= '{default: '0};
    end else if (wr_en) begin
      mem[wr_ptr] <= wr_data;
      wr_ptr      <= wr_ptr + addr_t'(1);
    end
  end

  assign tap_k_c  = mem[wr_ptr - k];
  assign tap_l_c  = mem[wr_ptr - l];
  assign tap_kl_c = mem[wr_ptr - k - l];

endmodule

// File: rtl/trap_shaper_v3.sv
// Trapezoidal shaper: d -> p -> r -> s recursion, shift and saturate, 4-clk latency.
module trap_shaper_v3
  import package_settings_v3::*;
#(
  parameter int unsigned OUT_SHIFT = 4,
  parameter int unsigned K_DEF     = 4,
  parameter int unsigned L_DEF     = 8,
  parameter int unsigned M_DEF     = 0
) (
  input logic             clk,
  input logic             reset,
  trap_shaper_v3_if.slave bus
);

  localparam acc_t OUT_MAX = acc_t'((1 << (OUT_W - 1)) - 1);
  localparam acc_t OUT_MIN = acc_t'(-(1 << (OUT_W - 1)));

  cfg_t    cfg_q;
  cfg_t    cfg_new_c;
  logic    flush_c;
  logic    accept_c;
  sample_t tap_k_c, tap_l_c, tap_kl_c;
  diff_t   d_c, d1_q;
  acc_t    m_ext_c, sh_c;
  acc_t    p_q, md2_q, r3_q, s_q;
  logic    v1_q, v2_q, v3_q, v4_q;
  out_t    out_c;
  logic    sat_c;

  assign cfg_new_c = '{k: bus.cfg_k, l: bus.cfg_l, m: bus.cfg_m};
  assign flush_c   = bus.cfg_load && cfg_ok(cfg_new_c);
  // An accepted reconfiguration wins over a sample arriving in the same cycle.
  assign accept_c  = bus.in_valid && !flush_c;

  trap_delay_line u_delay (
    .clk      (clk),
    .reset    (reset),
    .clr      (flush_c),
    .wr_en    (accept_c),
    .wr_data  (bus.in_data),
    .k        (cfg_q.k),
    .l        (cfg_q.l),
    .tap_k_c  (tap_k_c),
    .tap_l_c  (tap_l_c),
    .tap_kl_c (tap_kl_c)
  );

  assign d_c = D_W'(bus.in_data) - D_W'(tap_k_c) - D_W'(tap_l_c) + D_W'(tap_kl_c);
  assign m_ext_c = acc_t'(cfg_q.m);

  // Shift then clamp s into the signed output range.
  always_comb begin
    sh_c  = s_q >>> OUT_SHIFT;
    out_c = OUT_W'(sh_c);
    sat_c = 1'b0;
    if (sh_c > OUT_MAX) begin
      out_c = OUT_W'(OUT_MAX);
      sat_c = 1'b1;
    end else if (sh_c < OUT_MIN) begin
      out_c = OUT_W'(OUT_MIN);
      sat_c = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cfg_q       <= '{k: AW'(K_DEF), l: AW'(L_DEF), m: M_W'(M_DEF)};
      bus.cfg_err <= 1'b0;
    end else begin
      bus.cfg_err <= bus.cfg_load && !flush_c;
      if (flush_c) cfg_q <= cfg_new_c;
    end
  end

  // Each stage moves only when its own valid is set, so bubbles leave p and s untouched.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      {v1_q, v2_q, v3_q, v4_q} <= '0;
      d1_q          <= '0;
      p_q           <= '0;
      md2_q         <= '0;
      r3_q          <= '0;
      s_q           <= '0;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_sat   <= 1'b0;
    end else if (flush_c) begin
      {v1_q, v2_q, v3_q, v4_q} <= '0;
      p_q           <= '0;
      md2_q         <= '0;
      r3_q          <= '0;
      s_q           <= '0;
      bus.out_valid <= 1'b0;
    end else begin
      v1_q <= accept_c;
      if (accept_c) d1_q <= d_c;
      v2_q <= v1_q;
      if (v1_q) begin
        p_q   <= p_q + acc_t'(d1_q);
        md2_q <= acc_t'(d1_q) * m_ext_c;
      end
      v3_q <= v2_q;
      if (v2_q) r3_q <= p_q + md2_q;
      v4_q <= v3_q;
      if (v3_q) s_q <= s_q + r3_q;
      bus.out_valid <= v4_q;
      if (v4_q) begin
        bus.out_data <= out_c;
        bus.out_sat  <= sat_c;
      end
    end
  end

endmodule

// File: doc/trap_shaper_v3.md
# trap_shaper_v3

Parametrised trapezoidal pulse shaper for the ADC acquisition chain, and the successor to the fixed v2 filter. It accepts a valid-qualified stream of signed ADC samples and applies the k/l/M trapezoidal recursion (d → p → r → s). Delays k, l and the pole-zero factor M are run-time configurable. Output gain is set by a shift, and the result saturates to a valid-qualified output stream. It sits between the ADC front-end register and the peak/energy detector.

## Interface
- DATA_W, 14, input sample width (signed two's complement)
- AW, 6, delay-buffer address width; buffer depth 2^AW samples
- M_W, 10, width of unsigned M factor
- ACC_W, 40, width of internal p/r/s accumulators
- OUT_W, 16, output width (signed)
- OUT_SHIFT, 4, arithmetic right shift applied to s before saturation
- K_DEF / L_DEF / M_DEF, 4 / 8 / 0, configuration loaded at reset
- clk  in  1  clock; all logic rising-edge
- reset  in  1  asynchronous, active-low
- in_valid  in  1  in_data carries a sample this cycle
- in_data  in  DATA_W  signed ADC sample
- cfg_load  in  1  one-cycle strobe: apply cfg_k/cfg_l/cfg_m
- cfg_k  in  AW  rise/fall length k
- cfg_l  in  AW  l (flat top = l−k)
- cfg_m  in  M_W  pole-zero factor M
- cfg_err  out  1  registered; high one cycle after a rejected cfg_load
- out_valid  out  1  out_data valid this cycle
- out_data  out  OUT_W  saturated, shifted s
- out_sat  out  1  qualifies out_data: saturation occurred on this sample

## Operation
- Per accepted sample n (x = in_data): d(n) = x(n) − x(n−k) − x(n−l) + x(n−k−l); p(n) = p(n−1) + d(n); r(n) = p(n) + M·d(n); s(n) = s(n−1) + r(n).
- Delay history is a circular buffer written at wr_ptr on in_valid. wr_ptr increments mod 2^AW. Taps are read at wr_ptr−k, wr_ptr−l and wr_ptr−k−l, all mod 2^AW.
- Warm-up: history not yet written reads as 0, because the buffer is cleared on reset and on an accepted cfg_load.
- Config is valid iff 1 ≤ k ≤ l and k+l ≤ 2^AW − 1.
- Invalid config: registers keep their old values, nothing is flushed, cfg_err pulses for one cycle.
- Valid config: k/l/M are updated, and the buffer, wr_ptr, p, s and all pipeline valids are cleared in the same cycle.
- Arithmetic:
  - d is DATA_W+2 bits and is sign-extended to ACC_W.
  - M·d is signed × unsigned, with the result at ACC_W.
  - p, r and s wrap modulo 2^ACC_W; there is no internal saturation.
- Output = s >>> OUT_SHIFT, clamped to [−2^(OUT_W−1), 2^(OUT_W−1)−1]. out_sat = 1 when clamping occurred.
- Stages advance only with their own valid flag. Bubbles (in_valid = 0) insert no samples and do not alter p/s.

## Timing
- Reset values:
  - out_valid, out_data, out_sat and cfg_err are 0.
  - k/l/M take K_DEF/L_DEF/M_DEF.
  - Buffer, wr_ptr, p, r and s are 0.
- Pipeline: S1 computes d and registers it; S2 computes p and M·d; S3 computes r; S4 computes s, then shift and saturate into the output register.
- Latency is exactly 4 clk from an in_valid sample edge to its out_valid; out_valid is a one-cycle pulse per sample. Throughput is 1 sample/clk.
- cfg_load takes priority over in_valid in the same cycle: that sample is dropped and the flush applies.
- Samples already in flight when an accepted cfg_load arrives are discarded; no out_valid is produced for them.
- Reset asserted mid-stream clears everything asynchronously. The first out_valid after reset release comes 4 clk after the first accepted sample.

## Structure
- package_settings_v3 holds:
  - DATA_W, AW, M_W, ACC_W and OUT_W defaults;
  - typedefs sample_t, acc_t and cfg_t (a struct of k, l, m);
  - a function cfg_ok(cfg_t).
- Sub-module trap_delay_line: circular buffer with one write port, three combinational read taps and a synchronous clear. The top level holds config, pipeline, accumulators and saturation.

## Test plan
- Impulse, k=4, l=8, M=0, shift 0: one sample 50 followed by zeros. out_data must be 50,100,150,200,200,200,200,200,150,100,50,0, then 0. The first output appears 4 clk after the impulse.
- Step of 100, k=4, l=8, M=0: out_data ramps (100, 300, 600, 1000, …) and settles at k·l·100 = 3200 from the 12th output onward.
- Saturation, OUT_W=8, shift 0: step of 100. Outputs clamp at 127 with out_sat=1, and out_sat=0 on the unclamped early samples.
- Bubbles: the impulse test repeated with in_valid toggled 1-0-0 per sample must give an identical out_data sequence; out_valid stays high only on processed samples.
- Config:
  - cfg_load with k=9, l=4 gives cfg_err=1 and output unchanged.
  - cfg_load with k=2, l=3 mid-stream gives no out_valid for in-flight samples. A following impulse of 50 gives 50,100,100,50,0.
- Reset asserted mid-trapezoid: all outputs go to 0 immediately. After release, an impulse of 50 reproduces the first scenario exactly.
